dram_lsu: RTL and testbench
===========================

# dram_lsu

Load/store unit that initiates all data-memory traffic toward the word-addressed, synchronous-read/synchronous-write data RAM. It accepts byte-addressed RV32 load/store requests from the execute/memory stage, converts them to word accesses, extracts and sign/zero-extends sub-word load data, and performs read-modify-write for byte and halfword stores, because the RAM has only a whole-word write enable. It sits between the core's memory stage and the data RAM.

## Interface
- ADDR_W, 16, RAM word-address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request transfers when req_valid && req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  request rejected (misaligned or reserved size), valid with rsp_valid
- dram_a  out  ADDR_W  RAM word address
- dram_we  out  1  RAM write enable
- dram_din  out  32  RAM write data
- dram_spo  in  32  RAM read data, registered by RAM: valid the cycle after dram_a is presented

## Operation
- States: IDLE, RD (address on RAM), CAP (dram_spo valid), WR (dram_we high).
- Accept in IDLE: latch addr, size, we, unsigned, wdata; dram_a <= req_addr[ADDR_W+1:2]; upper address bits ignored (aliasing).
  - Word store -> WR. Load or sub-word store -> RD. Error -> stay IDLE, rsp_valid=1, rsp_err=1 next cycle, no RAM access.
- RD -> CAP unconditionally.
- CAP: load -> rsp_rdata <= extracted lane, rsp_valid <= 1, -> IDLE. Sub-word store -> dram_din <= dram_spo with selected lane(s) replaced by req_wdata low bits, -> WR.
- WR: dram_we = 1, dram_din stable; -> IDLE with rsp_valid <= 1, rsp_rdata <= 0.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]. Signed loads replicate lane MSB.
- Error: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- dram_we decoded from the state register only; never high outside WR.

## Timing
- Reset: state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; dram_a 0; dram_we 0; dram_din 0.
- Accept edge = E0. Word store: WR during E0–E1, commit at E1, rsp_valid cycle after E1. Load: RD E0–E1, CAP E1–E2, rsp_valid cycle after E2. Sub-word store: WR E2–E3, commit E3, rsp_valid cycle after E3. Error: rsp_valid cycle after E0.
- req_ready is high in the rsp_valid cycle, so back-to-back requests are accepted with zero bubble.
- rst_n low in any state: forced to IDLE immediately, dram_we drops asynchronously, pending write is not committed, and no rsp_valid is produced.
- rsp_rdata and rsp_err hold until the next rsp_valid.

## Configuration
- DRAM_LSU_MISALIGN_TRAP_EN defined: misaligned accesses are rejected with rsp_err as above.
- Undefined: misaligned addresses are silently aligned down (half: addr[0] cleared; word: addr[1:0] cleared), and the access proceeds normally. Size 11 is still an error. rsp_err is tied 0 except for size 11.

## Structure
- Package dram_lsu_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_RSV), state enum, and the extend/merge helper functions.
- One sub-module, dram_lane_align (combinational): inputs raw word, addr[1:0], size, unsigned, and store data. Outputs the extended load value and the merged store word. Shared by the CAP load path and the CAP store path.

## Test plan
- sw 0xDEADBEEF to 0x10 -> one dram_we cycle, dram_a=0x0004, dram_din=0xDEADBEEF, rsp_valid one cycle after the commit edge, rsp_err=0.
- RAM[4]=0x8899AABB; lb 0x13 -> rsp_rdata 0xFFFFFF88; lbu 0x13 -> 0x00000088; lh 0x10 -> 0xFFFFAABB; lhu 0x12 -> 0x00008899.
- RAM[4]=0x8899AABB; sh 0x1234 to 0x12 -> dram_din 0x1234AABB. Then sb 0x55 to 0x11 -> 0x123455BB. dram_we asserted exactly once per store.
- lw 0x11 with macro defined -> rsp_err=1 one cycle after accept, dram_we never high. Macro undefined -> returns RAM[4].
- lw 0x10 accepted in the same cycle as the previous rsp_valid -> zero-bubble; req_ready low in RD/CAP/WR.
- rst_n pulsed low during WR of a sb -> RAM unchanged, no rsp_valid, all outputs at reset values, next request served normally.

Source files
------------

// File: rtl/dram_lsu_pkg.sv
// Shared types and lane helpers for the data-RAM load/store unit.
package dram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StCap,
        StWr
    } state_e;

    // Pick the addressed lane out of a RAM word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] off,
                                                input size_e size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = off[1] ? raw[31:16] : raw[15:0];
        case (size)
            SZ_B:    load_extend = {{24{b[7] & ~uns}}, b};
            SZ_H:    load_extend = {{16{h[15] & ~uns}}, h};
            default: load_extend = raw;
        endcase
    endfunction

    // Replace the addressed lane(s) of the old RAM word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] raw, input logic [1:0] off,
                                                input size_e size, input logic [31:0] wdata);
        store_merge = raw;
        case (size)
            SZ_B: store_merge[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (off[1]) store_merge[31:16] = wdata[15:0];
                else        store_merge[15:0]  = wdata[15:0];
            end
            default: store_merge = wdata;
        endcase
    endfunction

endpackage

// File: rtl/dram_lane_align.sv
// Combinational lane steering: extended load value and read-modify-write store word.
module dram_lane_align
    import dram_lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    assign load_val   = load_extend(raw, off, size, uns);
    assign store_word = store_merge(raw, off, size, wdata);

endmodule

// File: rtl/dram_lsu.sv
// Byte-addressed RV32 load/store front end for a word-wide synchronous data RAM.
// Define DRAM_LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them down.
module dram_lsu
    import dram_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dram_a,
    output logic              dram_we,
    output logic [31:0]       dram_din,
    input  logic [31:0]       dram_spo
);

    state_e            state_q, state_d;
    size_e             req_sz, size_q;
    logic [1:0]        req_off, off_q;
    logic              req_err, accept;
    logic              we_q, uns_q;
    logic [31:0]       wdata_q, din_q, rdata_q;
    logic [ADDR_W-1:0] dram_a_q;
    logic              rsp_valid_q, err_q;
    logic [31:0]       load_val, store_word;
    logic              unused_addr;

    assign req_sz      = size_e'(req_size);
    assign accept      = req_valid && req_ready;
    // Upper byte-address bits alias onto the RAM.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    always_comb begin
        req_off = req_addr[1:0];
        req_err = (req_sz == SZ_RSV);
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
        if (req_sz == SZ_H && req_addr[0])          req_err = 1'b1;
        if (req_sz == SZ_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
`else
        if (req_sz == SZ_H) req_off[0] = 1'b0;
        if (req_sz == SZ_W) req_off    = 2'b00;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !req_err) begin
                    state_d = (req_we && req_sz == SZ_W) ? StWr : StRd;
                end
            end
            StRd:    state_d = StCap;
            StCap:   state_d = we_q ? StWr : StIdle;
            StWr:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Write enable comes straight from the state register so reset kills it asynchronously.
    always_comb begin
        req_ready = (state_q == StIdle);
        dram_we   = (state_q == StWr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= 2'b00;
            size_q      <= SZ_B;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            dram_a_q    <= '0;
            din_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        off_q    <= req_off;
                        size_q   <= req_sz;
                        we_q     <= req_we;
                        uns_q    <= req_unsigned;
                        wdata_q  <= req_wdata;
                        dram_a_q <= req_addr[ADDR_W+1:2];
                        if (req_err) begin
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= 32'd0;
                            err_q       <= 1'b1;
                        end else if (req_we && req_sz == SZ_W) begin
                            din_q <= req_wdata;
                        end
                    end
                end
                StCap: begin
                    if (we_q) begin
                        din_q <= store_word;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= load_val;
                        err_q       <= 1'b0;
                    end
                end
                StWr: begin
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= 32'd0;
                    err_q       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    dram_lane_align u_lane_align (
        .raw        (dram_spo),
        .off        (off_q),
        .size       (size_q),
        .uns        (uns_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dram_a    = dram_a_q;
    assign dram_din  = din_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Randomized bench for dram_lsu against a byte-level memory model with a cycle-exact scoreboard.
module tb_dram_lsu;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              req_ready, rsp_valid, rsp_err, dram_we;
    logic [31:0]       rsp_rdata, dram_din, dram_spo;
    logic [ADDR_W-1:0] dram_a;

    dram_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dram_a       (dram_a),
        .dram_we      (dram_we),
        .dram_din     (dram_din),
        .dram_spo     (dram_spo)
    );

    initial forever #5 clk = ~clk;

    // Synchronous RAM with a preload port used only while in reset.
    logic [31:0] mem [0:65535];
    logic        init_we = 1'b0;
    logic [15:0] init_a = 16'd0;
    logic [31:0] init_d = 32'd0;
    always @(posedge clk) begin
        if (init_we)      mem[init_a] <= init_d;
        else if (dram_we) mem[dram_a] <= dram_din;
        dram_spo <= mem[dram_a];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_bytes [0:255];

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
    } rsp_t;
    typedef struct {
        int                due;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;
    rsp_t rspq[$];
    wr_t  wrq[$];
    int   busy_acc = 0, busy_due = 0, last_acc = 0, last_due = 0;
    bit   run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_dram_a", dram_a, 0);
        check("rst_dram_we", dram_we, 0);
        check("rst_dram_din", dram_din, 0);
    endtask

    // Present one request at a negedge where the DUT is ready; model its effect and timing.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit commit,
                         output logic [31:0] exp_rd, output logic exp_err,
                         output logic [31:0] exp_wr);
        int          w, n, k, acc;
        logic [7:0]  ea;
        logic [7:0]  lane [4];
        logic [31:0] v;
        rsp_t        r;
        wr_t         wq;
        exp_rd  = 32'd0;
        exp_wr  = 32'd0;
        exp_err = 1'b0;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("accept_timeout", req_ready, 1);
            return;
        end
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        ea = addr[7:0];
        exp_err = (size == 2'd3);
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
        if (!exp_err && (ea & 8'(n - 1)) != 8'd0) exp_err = 1'b1;
`else
        if (!exp_err) ea = ea & ~8'(n - 1);
`endif
        for (int i = 0; i < 4; i++) lane[i] = ref_bytes[{ea[7:2], 2'b00} + i];
        if (exp_err) begin
            k = 0;
        end else if (!we) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(lane[ea[1:0] + i]) << (8 * i));
            if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_rd = v;
            k = 2;
        end else begin
            for (int i = 0; i < n; i++) lane[ea[1:0] + i] = wdata[8 * i +: 8];
            exp_wr = {lane[3], lane[2], lane[1], lane[0]};
            if (commit) for (int i = 0; i < 4; i++) ref_bytes[{ea[7:2], 2'b00} + i] = lane[i];
            k = (n == 4) ? 1 : 3;
        end
        acc = cyc + 1;
        if (commit) begin
            r.due = acc + k;
            r.rd  = exp_rd;
            r.err = exp_err;
            rspq.push_back(r);
        end
        if (we && !exp_err) begin
            wq.due = acc + ((k == 1) ? 0 : 2);
            wq.a   = addr[ADDR_W+1:2];
            wq.d   = exp_wr;
            wrq.push_back(wq);
        end
        busy_acc = acc;
        busy_due = acc + k;
        last_acc = acc;
        last_due = acc + k;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Every-cycle scoreboard: ready, responses and RAM writes against the expected schedule.
    rsp_t cr;
    wr_t  cw;
    always @(negedge clk) begin
        if (rst_n && run) begin
            check("req_ready", req_ready, (busy_acc <= cyc && cyc < busy_due) ? 0 : 1);
            if (rsp_valid) begin
                if (rspq.size() != 0 && rspq[0].due == cyc) begin
                    cr = rspq.pop_front();
                    check("rsp_rdata", rsp_rdata, cr.rd);
                    check("rsp_err", rsp_err, cr.err);
                end else begin
                    check("rsp_unexpected", rsp_valid, 0);
                end
            end else if (rspq.size() != 0 && rspq[0].due <= cyc) begin
                check("rsp_missing", rsp_valid, 1);
                cr = rspq.pop_front();
            end
            if (dram_we) begin
                if (wrq.size() != 0 && wrq[0].due == cyc) begin
                    cw = wrq.pop_front();
                    check("dram_a", dram_a, cw.a);
                    check("dram_din", dram_din, cw.d);
                end else begin
                    check("we_unexpected", dram_we, 0);
                end
            end else if (wrq.size() != 0 && wrq[0].due <= cyc) begin
                check("we_missing", dram_we, 1);
                cw = wrq.pop_front();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] rd, wr, ad;
        logic        er;
        logic [1:0]  sz;
        int          a0;

        // Preload words 0..63 of RAM and the model while in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            init_we = 1'b1;
            init_a  = 16'(i);
            init_d  = $urandom;
            for (int j = 0; j < 4; j++) ref_bytes[4 * i + j] = init_d[8 * j +: 8];
        end
        @(negedge clk);
        init_we = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, rd, er, wr);
        check("sw_model_word", wr, 32'hDEADBEEF);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, 1'b1, rd, er, wr);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b1, rd, er, wr);
        check("lb_model", rd, 32'hFFFFFF88);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1, rd, er, wr);
        check("lbu_model", rd, 32'h00000088);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 1'b1, rd, er, wr);
        check("lh_model", rd, 32'hFFFFAABB);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b1, rd, er, wr);
        check("lhu_model", rd, 32'h00008899);
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 1'b1, rd, er, wr);
        check("sh_model_merge", wr, 32'h1234AABB);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 1'b1, rd, er, wr);
        check("sb_model_merge", wr, 32'h123455BB);

        a0 = last_due;
        issue(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, 1'b1, rd, er, wr);
        check("zero_bubble_after_store", last_acc, a0 + 1);
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
        check("lw_misaligned_err_model", er, 1);
`else
        check("lw_misaligned_align_model", rd, 32'h123455BB);
`endif
        a0 = last_due;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, rd, er, wr);
        check("zero_bubble_after_lw", last_acc, a0 + 1);
        a0 = last_due;
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1'b1, rd, er, wr);
        check("zero_bubble_after_load", last_acc, a0 + 1);
        check("rsv_size_err_model", er, 1);

        // Reset during the write cycle of a byte store: nothing commits, nothing responds.
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h77, 1'b0, rd, er, wr);
        repeat (2) @(negedge clk);
        check("rst_test_in_wr", dram_we, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 check("rst_no_commit", mem[4], 32'h123455BB);
        busy_due = 0;
        rspq.delete();
        wrq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, rd, er, wr);
        check("after_rst_lw_model", rd, 32'h123455BB);

        for (int n = 0; n < 300; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 255));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b1,
                  rd, er, wr);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("rsp_drain", rspq.size(), 0);
        check("wr_drain", wrq.size(), 0);
        for (int i = 0; i < 64; i++) begin
            check("ram_final", mem[i], {ref_bytes[4 * i + 3], ref_bytes[4 * i + 2],
                                        ref_bytes[4 * i + 1], ref_bytes[4 * i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
